// File: rtl/calf_port_alloc.sv
// Output-port allocator for the CALF bufferless deflection router: places every valid flit on a
// distinct output port or the single eject slot, round-robin priority, registered results.
// Optional deflection counter is built when CALF_ALLOC_STATS_EN is defined.
module calf_port_alloc #(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned RR_RESET = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       valid_in,
  input  logic [15:0]      rmatrix_in,
  input  logic             eject_ready,
  output logic [3:0]       grant_v,
  output logic [7:0]       port_sel,
  output logic [3:0]       eject_v,
  output logic [3:0]       deflect
`ifdef CALF_ALLOC_STATS_EN
  ,
  output logic [CNT_W-1:0] defl_count
`endif
);

  function automatic logic [1:0] lowest_port(input logic [3:0] mask);
    lowest_port = 2'd0;
    for (int b = 3; b >= 0; b--) begin
      if (mask[b]) lowest_port = 2'(b);
    end
  endfunction

  logic [1:0] rr_ptr_q, rr_ptr_d;
  logic [3:0] grant_q, grant_d;
  logic [7:0] port_sel_q, port_sel_d;
  logic [3:0] eject_q, eject_d;
  logic [3:0] deflect_q, deflect_d;

  // Per-slot scratch of the sequential service loop.
  logic [3:0] port_free;
  logic       eject_used;
  logic [1:0] idx;
  logic [3:0] rm;
  logic [3:0] avail;
  logic [1:0] pick;

  // NOTE: every variable written here gets a default first, so no path leaves a latch.
  always_comb begin
    port_free  = 4'b1111;
    eject_used = 1'b0;
    idx        = 2'd0;
    rm         = 4'd0;
    avail      = 4'd0;
    pick       = 2'd0;
    grant_d    = 4'd0;
    port_sel_d = 8'd0;
    eject_d    = 4'd0;
    deflect_d  = 4'd0;
    // NOTE: blocking assignments are deliberate; port_free/eject_used carry from one served
    // input to the next within the same cycle.
    for (int k = 0; k < 4; k++) begin
      idx = rr_ptr_q + 2'(k);
      rm  = rmatrix_in[idx*4 +: 4];
      if (valid_in[idx]) begin
        if (rm == 4'd0 && eject_ready && !eject_used) begin
          eject_used   = 1'b1;
          eject_d[idx] = 1'b1;
        end else begin
          avail = rm & port_free;
          if (avail != 4'd0) begin
            pick = lowest_port(avail);
          end else begin
            // Deflection: any free port; one always exists since ports >= inputs.
            pick           = lowest_port(port_free);
            deflect_d[idx] = 1'b1;
          end
          port_free[pick]         = 1'b0;
          grant_d[idx]            = 1'b1;
          port_sel_d[idx*2 +: 2]  = pick;
        end
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (|valid_in) rr_ptr_d = rr_ptr_q + 2'd1;
  end

  // NOTE: synchronous reset, so rst appears only inside the clocked block's body.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q   <= RR_RESET[1:0];
      grant_q    <= '0;
      port_sel_q <= '0;
      eject_q    <= '0;
      deflect_q  <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      port_sel_q <= port_sel_d;
      eject_q    <= eject_d;
      deflect_q  <= deflect_d;
    end
  end

  assign grant_v  = grant_q;
  assign port_sel = port_sel_q;
  assign eject_v  = eject_q;
  assign deflect  = deflect_q;

`ifdef CALF_ALLOC_STATS_EN
  localparam int unsigned SUM_W = CNT_W + 3;
  localparam logic [SUM_W-1:0] SAT = {3'b000, {CNT_W{1'b1}}};

  logic [CNT_W-1:0] defl_count_q, defl_count_d;
  logic [2:0]       defl_pop;
  logic [SUM_W-1:0] defl_sum;

  always_comb begin
    defl_pop = 3'd0;
    for (int b = 0; b < 4; b++) defl_pop = defl_pop + {2'b00, deflect_d[b]};
    defl_sum     = SUM_W'(defl_count_q) + SUM_W'(defl_pop);
    defl_count_d = (defl_sum > SAT) ? {CNT_W{1'b1}} : defl_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) defl_count_q <= '0;
    else     defl_count_q <= defl_count_d;
  end

  assign defl_count = defl_count_q;
`endif

endmodule

// File: tb/tb_calf_port_alloc.sv
// Scoreboard bench for calf_port_alloc: directed cases plus randomized traffic checked
// against a behavioural allocation model.
module tb_calf_port_alloc;

  localparam int unsigned CNT_W    = 4;
  localparam int unsigned RR_RESET = 0;
  localparam longint      CNT_MAX  = (64'd1 << CNT_W) - 1;

  typedef struct {
    logic [3:0] grant;
    logic [7:0] ps;
    logic [3:0] ej;
    logic [3:0] df;
    longint     cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  valid_in = '0;
  logic [15:0] rmatrix_in = '0;
  logic        eject_ready = 1'b0;
  logic [3:0]  grant_v, eject_v, deflect;
  logic [7:0]  port_sel;
`ifdef CALF_ALLOC_STATS_EN
  logic [CNT_W-1:0] defl_count;
`endif

  calf_port_alloc #(.CNT_W(CNT_W), .RR_RESET(RR_RESET)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .rmatrix_in(rmatrix_in),
    .eject_ready(eject_ready), .grant_v(grant_v), .port_sel(port_sel),
    .eject_v(eject_v), .deflect(deflect)
`ifdef CALF_ALLOC_STATS_EN
    , .defl_count(defl_count)
`endif
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];

  // Model state
  int     m_rr  = RR_RESET;
  longint m_cnt = 0;

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int popc(input logic [3:0] v);
    int c = 0;
    for (int b = 0; b < 4; b++) c += int'(v[b]);
    return c;
  endfunction

  // Allocation as a walk over inputs in priority order, tracking taken ports.
  function automatic exp_t ref_alloc(input int rr, input logic [3:0] v,
                                     input logic [15:0] rm, input bit er);
    exp_t e;
    bit   used[4];
    bit   ej_taken;
    int   i, want;
    logic [3:0] r;
    e.grant = '0; e.ps = '0; e.ej = '0; e.df = '0; e.cnt = 0;
    for (int p = 0; p < 4; p++) used[p] = 1'b0;
    ej_taken = 1'b0;
    for (int k = 0; k < 4; k++) begin
      i = (rr + k) % 4;
      r = rm[4*i +: 4];
      if (v[i]) begin
        if (r == 4'd0 && er && !ej_taken) begin
          ej_taken = 1'b1;
          e.ej[i]  = 1'b1;
        end else begin
          want = -1;
          for (int p = 0; p < 4; p++) if (want < 0 && r[p] && !used[p]) want = p;
          if (want < 0) begin
            for (int p = 0; p < 4; p++) if (want < 0 && !used[p]) want = p;
            e.df[i] = 1'b1;
          end
          used[want]    = 1'b1;
          e.grant[i]    = 1'b1;
          e.ps[2*i +: 2] = 2'(want);
        end
      end
    end
    return e;
  endfunction

  // Drive one cycle at negedge and push its expected registered response.
  task automatic step(input bit r, input logic [3:0] v, input logic [15:0] rm, input bit er,
                      input bit use_fixed, input exp_t fixed);
    exp_t e;
    @(negedge clk);
    rst = r; valid_in = v; rmatrix_in = rm; eject_ready = er;
    if (r) begin
      e.grant = '0; e.ps = '0; e.ej = '0; e.df = '0;
      m_rr = RR_RESET; m_cnt = 0;
    end else begin
      e = use_fixed ? fixed : ref_alloc(m_rr, v, rm, er);
      if (|v) m_rr = (m_rr + 1) % 4;
      m_cnt += popc(e.df);
      if (m_cnt > CNT_MAX) m_cnt = CNT_MAX;
    end
    e.cnt = m_cnt;
    exp_q.push_back(e);
  endtask

  function automatic exp_t mk(input logic [3:0] g, input logic [7:0] ps,
                              input logic [3:0] ej, input logic [3:0] df);
    exp_t e;
    e.grant = g; e.ps = ps; e.ej = ej; e.df = df; e.cnt = 0;
    return e;
  endfunction

  function automatic logic [3:0] rand_rm();
    logic [3:0] r;
    case ($urandom_range(0, 3))
      0: r = 4'd0;
      1: r = 4'(1 << $urandom_range(0, 3));
      2: r = {2'(1 << $urandom_range(0, 1)), 2'(1 << $urandom_range(0, 1))};
      default: r = 4'($urandom());
    endcase
    return r;
  endfunction

  // Monitor: outputs are presented every cycle; compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("grant_v", grant_v, e.grant);
        check("port_sel", port_sel, e.ps);
        check("eject_v", eject_v, e.ej);
        check("deflect", deflect, e.df);
`ifdef CALF_ALLOC_STATS_EN
        check("defl_count", defl_count, e.cnt);
`endif
      end
    end
  end

  initial begin
    exp_t none;
    logic [15:0] rm;
    none = mk(4'h0, 8'h00, 4'h0, 4'h0);

    // Reset: all outputs zero, pointer at RR_RESET.
    step(1, 4'h0, 16'h0, 0, 1, none);
    step(1, 4'h0, 16'h0, 0, 1, none);
    // Single flit heading east.
    step(0, 4'b0001, 16'h0004, 0, 1, mk(4'b0001, 8'h02, 4'h0, 4'h0));
    // Two north-bound flits, priority rotates between them.
    step(1, 4'h0, 16'h0, 0, 1, none);
    step(0, 4'b0011, 16'h0011, 0, 1, mk(4'b0011, 8'h04, 4'h0, 4'b0010));
    step(0, 4'b0011, 16'h0011, 0, 1, mk(4'b0011, 8'h01, 4'h0, 4'b0001));
    // rr_ptr=2: all at destination, one ejects, three deflect.
    step(0, 4'b1111, 16'h0000, 1, 1, mk(4'b1011, 8'h09, 4'b0100, 4'b1011));
    // Bring rr_ptr to 2 with an idle cycle in between (pointer holds when idle).
    step(1, 4'h0, 16'h0, 0, 1, none);
    step(0, 4'b0001, 16'h0004, 0, 1, mk(4'b0001, 8'h02, 4'h0, 4'h0));
    step(0, 4'b0000, 16'hFFFF, 1, 1, none);
    step(0, 4'b0001, 16'h0004, 0, 1, mk(4'b0001, 8'h02, 4'h0, 4'h0));
    // No eject slot: all four deflect to ports in service order 2,3,0,1.
    step(0, 4'b1111, 16'h0000, 0, 1, mk(4'b1111, 8'h4E, 4'h0, 4'b1111));

`ifdef CALF_ALLOC_STATS_EN
    // Saturation: three deflections per cycle regardless of pointer.
    step(1, 4'h0, 16'h0, 0, 1, none);
    for (int n = 0; n < 6; n++) step(0, 4'b1111, 16'h0000, 1, 0, none);
`endif

    // Randomized traffic with occasional mid-run reset.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) rm[4*i +: 4] = rand_rm();
      step(($urandom_range(0, 59) == 0), 4'($urandom()), rm,
           ($urandom_range(0, 3) != 0), 0, none);
    end
    step(0, 4'h0, 16'h0, 0, 0, none);

    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
